// File: rtl/change_dispenser.sv
// change_dispenser
//
// Computes the change for a purchase, plans a greedy coin breakdown over three
// denominations (HI/MID/LO) bounded by the on-board coin stock, dispenses the
// planned coins one per handshake to the coin ejector, then reports the result.
//
// Ports:
//   clk                - system clock, rising edge
//   reset              - asynchronous, active-low reset
//   start              - transaction request, sampled in IDLE only
//   current_amount     - money inserted
//   product_price      - price of the selected product
//   coin_ready         - ejector accepts the offered coin this cycle
//   refill             - stock refill strobe, honoured in IDLE only
//   refill_sel         - 0=LO, 1=MID, 2=HI, 3=ignored
//   refill_qty         - coins added by a refill (saturating)
//   busy               - high in every state except IDLE
//   coin_valid         - coin request to the ejector
//   coin_sel           - denomination of the requested coin: 0=LO, 1=MID, 2=HI
//   done               - one-cycle completion pulse
//   valid_transaction  - result of the last transaction
//   change_amount      - change of the last transaction (0 on failure)
//   stock_hi/mid/lo    - current coin stock per denomination
//   state_dbg          - current FSM state encoding, for observation only
//
// Coin handshake: a coin transfers on every rising edge where coin_valid and
// coin_ready are both high. While coin_valid is high and coin_ready is low,
// coin_sel is held stable; coin_valid never drops without a transfer except
// on reset.

module change_dispenser #(
    parameter int AMT_W      = 8,
    parameter int STOCK_W    = 6,
    parameter int COIN_HI    = 10,
    parameter int COIN_MID   = 5,
    parameter int COIN_LO    = 1,
    parameter int INIT_STOCK = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [AMT_W-1:0]   current_amount,
    input  logic [AMT_W-1:0]   product_price,
    input  logic               coin_ready,
    input  logic               refill,
    input  logic [1:0]         refill_sel,
    input  logic [STOCK_W-1:0] refill_qty,
    output logic               busy,
    output logic               coin_valid,
    output logic [1:0]         coin_sel,
    output logic               done,
    output logic               valid_transaction,
    output logic [AMT_W-1:0]   change_amount,
    output logic [STOCK_W-1:0] stock_hi,
    output logic [STOCK_W-1:0] stock_mid,
    output logic [STOCK_W-1:0] stock_lo,
    output logic [2:0]         state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PLAN     = 3'd1,
        S_DISPENSE = 3'd2,
        S_DONE     = 3'd3,
        S_FAIL     = 3'd4
    } state_t;

    localparam logic [AMT_W-1:0]   HI_V       = AMT_W'(COIN_HI);
    localparam logic [AMT_W-1:0]   MID_V      = AMT_W'(COIN_MID);
    localparam logic [AMT_W-1:0]   LO_V       = AMT_W'(COIN_LO);
    localparam logic [STOCK_W-1:0] STOCK_INIT = STOCK_W'(INIT_STOCK);

    state_t state_q, state_d;

    logic [AMT_W-1:0]   rem_q;
    logic [AMT_W-1:0]   change_reg_q;
    logic [STOCK_W-1:0] plan_hi_q, plan_mid_q, plan_lo_q;
    logic [STOCK_W-1:0] stock_hi_q, stock_mid_q, stock_lo_q;
    logic               valid_q;
    logic [AMT_W-1:0]   change_q;

    logic               use_hi, use_mid, use_lo;
    logic               any_plan;
    logic               last_coin;
    logic [1:0]         disp_sel;
    logic [STOCK_W+1:0] plan_total;
    logic               refill_ok;

    // Saturating stock add: the extra bit catches the carry out.
    function automatic logic [STOCK_W-1:0] sat_add(input logic [STOCK_W-1:0] a,
                                                   input logic [STOCK_W-1:0] b);
        logic [STOCK_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[STOCK_W] ? {STOCK_W{1'b1}} : sum[STOCK_W-1:0];
    endfunction

    // Greedy plan step, highest denomination first, each bounded by the stock
    // so that dispensing can never underflow a counter.
    always_comb begin
        use_hi  = (rem_q >= HI_V) && (plan_hi_q < stock_hi_q);
        use_mid = !use_hi && (rem_q >= MID_V) && (plan_mid_q < stock_mid_q);
        use_lo  = !use_hi && !use_mid && (rem_q >= LO_V) && (plan_lo_q < stock_lo_q);
    end

    assign any_plan   = (plan_hi_q != '0) || (plan_mid_q != '0) || (plan_lo_q != '0);
    assign plan_total = {2'b00, plan_hi_q} + {2'b00, plan_mid_q} + {2'b00, plan_lo_q};
    assign last_coin  = (plan_total == (STOCK_W+2)'(1));
    assign disp_sel   = (plan_hi_q != '0) ? 2'd2 : ((plan_mid_q != '0) ? 2'd1 : 2'd0);

    // A refill coinciding with an accepted start is dropped: the transaction
    // has already claimed the stock for planning.
    assign refill_ok  = (state_q == S_IDLE) && !start && refill;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (current_amount < product_price) ? S_FAIL : S_PLAN;
                end
            end
            S_PLAN: begin
                if (use_hi || use_mid || use_lo) begin
                    state_d = S_PLAN;
                end else if (rem_q == '0) begin
                    state_d = any_plan ? S_DISPENSE : S_DONE;
                end else begin
                    state_d = S_FAIL;
                end
            end
            S_DISPENSE: begin
                if (coin_ready && last_coin) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_FAIL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath: remainder, plan counters, stock counters and result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem_q        <= '0;
            change_reg_q <= '0;
            plan_hi_q    <= '0;
            plan_mid_q   <= '0;
            plan_lo_q    <= '0;
            stock_hi_q   <= STOCK_INIT;
            stock_mid_q  <= STOCK_INIT;
            stock_lo_q   <= STOCK_INIT;
            valid_q      <= 1'b0;
            change_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && (current_amount >= product_price)) begin
                        rem_q        <= current_amount - product_price;
                        change_reg_q <= current_amount - product_price;
                        plan_hi_q    <= '0;
                        plan_mid_q   <= '0;
                        plan_lo_q    <= '0;
                    end
                    if (refill_ok) begin
                        case (refill_sel)
                            2'd0:    stock_lo_q  <= sat_add(stock_lo_q, refill_qty);
                            2'd1:    stock_mid_q <= sat_add(stock_mid_q, refill_qty);
                            2'd2:    stock_hi_q  <= sat_add(stock_hi_q, refill_qty);
                            default: ;
                        endcase
                    end
                end
                S_PLAN: begin
                    if (use_hi) begin
                        plan_hi_q <= plan_hi_q + 1'b1;
                        rem_q     <= rem_q - HI_V;
                    end else if (use_mid) begin
                        plan_mid_q <= plan_mid_q + 1'b1;
                        rem_q      <= rem_q - MID_V;
                    end else if (use_lo) begin
                        plan_lo_q <= plan_lo_q + 1'b1;
                        rem_q     <= rem_q - LO_V;
                    end
                end
                S_DISPENSE: begin
                    if (coin_ready) begin
                        case (disp_sel)
                            2'd2: begin
                                plan_hi_q  <= plan_hi_q - 1'b1;
                                stock_hi_q <= stock_hi_q - 1'b1;
                            end
                            2'd1: begin
                                plan_mid_q  <= plan_mid_q - 1'b1;
                                stock_mid_q <= stock_mid_q - 1'b1;
                            end
                            default: begin
                                plan_lo_q  <= plan_lo_q - 1'b1;
                                stock_lo_q <= stock_lo_q - 1'b1;
                            end
                        endcase
                    end
                end
                default: ;
            endcase

            // Results are published as DONE/FAIL is entered so they are
            // visible together with the done pulse, and then held.
            if (state_d == S_DONE) begin
                valid_q  <= 1'b1;
                change_q <= change_reg_q;
            end else if (state_d == S_FAIL) begin
                valid_q  <= 1'b0;
                change_q <= '0;
            end
        end
    end

    assign busy              = (state_q != S_IDLE);
    assign coin_valid        = (state_q == S_DISPENSE);
    assign coin_sel          = coin_valid ? disp_sel : 2'd0;
    assign done              = (state_q == S_DONE) || (state_q == S_FAIL);
    assign valid_transaction = valid_q;
    assign change_amount     = change_q;
    assign stock_hi          = stock_hi_q;
    assign stock_mid         = stock_mid_q;
    assign stock_lo          = stock_lo_q;
    assign state_dbg         = state_q;

endmodule
